// File: rtl/flit_rr_arbiter_pkg.sv
// Flit format shared by the router input stage, plus the header decode helpers
// that keep flit-type knowledge out of the arbiter itself.
package flit_rr_arbiter_pkg;

   typedef enum logic [1:0] {
      FLIT_BODY      = 2'd0,
      FLIT_HEAD      = 2'd1,
      FLIT_TAIL      = 2'd2,
      FLIT_HEAD_TAIL = 2'd3
   } flit_type_e;

   typedef struct packed {
      flit_type_e  ftype;
      logic [7:0]  src_id;
      logic [21:0] payload;
   } flit_t;

   localparam int FLIT_W = $bits(flit_t);

   // A single-flit packet is both head and tail, so it also releases the lock.
   function automatic logic is_tail_flit(input flit_t f);
      return (f.ftype == FLIT_TAIL) || (f.ftype == FLIT_HEAD_TAIL);
   endfunction

   function automatic logic is_head_flit(input flit_t f);
      return (f.ftype == FLIT_HEAD) || (f.ftype == FLIT_HEAD_TAIL);
   endfunction

endpackage

// File: rtl/flit_rr_arbiter_picker.sv
// Rotating-priority search: first asserted request at or after ptr_i, wrapping
// at NUM_PORTS. Purely combinational so allocators can reuse it in any stage.
module rr_priority_picker #(
   parameter int NUM_PORTS     = 4,
   parameter int PORT_ID_WIDTH = $clog2(NUM_PORTS)
) (
   input  logic [NUM_PORTS-1:0]     req_i,
   input  logic [PORT_ID_WIDTH-1:0] ptr_i,
   output logic                     found_o,
   output logic [PORT_ID_WIDTH-1:0] idx_o
);

   // One extra bit holds ptr + offset before the wrap subtraction.
   localparam logic [PORT_ID_WIDTH:0] NP = (PORT_ID_WIDTH+1)'(NUM_PORTS);

   logic [PORT_ID_WIDTH:0]   sum;
   logic [PORT_ID_WIDTH-1:0] cand;

   always_comb begin
      found_o = 1'b0;
      idx_o   = '0;
      sum     = '0;
      cand    = '0;
      for (int k = 0; k < NUM_PORTS; k++) begin
         sum = {1'b0, ptr_i} + (PORT_ID_WIDTH+1)'(k);
         if (sum >= NP) begin
            sum = sum - NP;
         end
         cand = sum[PORT_ID_WIDTH-1:0];
         if (!found_o && req_i[cand]) begin
            found_o = 1'b1;
            idx_o   = cand;
         end
      end
   end

endmodule

// File: rtl/flit_rr_arbiter.sv
// Round-robin arbiter feeding one shared flit_queue push port; the grant is held
// from head to tail so packets from different sources never interleave.
module flit_rr_arbiter
   import flit_rr_arbiter_pkg::*;
#(
   parameter int NUM_PORTS     = 4,
   parameter int PORT_ID_WIDTH = $clog2(NUM_PORTS)
) (
   input  logic                         clk,
   input  logic                         rst,
   input  flit_t [NUM_PORTS-1:0]        in_flit,
   input  logic  [NUM_PORTS-1:0]        in_flit_valid,
   output logic  [NUM_PORTS-1:0]        in_flit_ready,
   output flit_t                        out_flit,
   output logic                         out_flit_valid,
   input  logic                         out_flit_ready,
   output logic  [PORT_ID_WIDTH-1:0]    grant_port,
   output logic                         locked
);

   typedef enum logic {IDLE, LOCKED} arb_state_t;

   localparam logic [PORT_ID_WIDTH-1:0] LAST_PORT = PORT_ID_WIDTH'(NUM_PORTS - 1);

   arb_state_t               state_q, state_d;
   flit_t                    flit_q, flit_d;
   logic                     vld_q, vld_d;
   logic [PORT_ID_WIDTH-1:0] grant_q, grant_d;
   logic [PORT_ID_WIDTH-1:0] rr_ptr_q, rr_ptr_d;

   logic                     slot_free;
   logic                     pick_found;
   logic [PORT_ID_WIDTH-1:0] pick_idx;
   logic                     win_req;
   logic [PORT_ID_WIDTH-1:0] win_idx;
   flit_t                    win_flit;
   logic                     xfer;

   rr_priority_picker #(
      .NUM_PORTS     (NUM_PORTS),
      .PORT_ID_WIDTH (PORT_ID_WIDTH)
   ) u_picker (
      .req_i   (in_flit_valid),
      .ptr_i   (rr_ptr_q),
      .found_o (pick_found),
      .idx_o   (pick_idx)
   );

   // The output slot can take a new flit when empty or being popped this cycle.
   assign slot_free = !vld_q || out_flit_ready;

   // While locked the granted source alone is offered ready, even if it is idle.
   always_comb begin
      win_idx = pick_idx;
      win_req = pick_found;
      if (state_q == LOCKED) begin
         win_idx = grant_q;
         win_req = 1'b1;
      end
      in_flit_ready = '0;
      if (!rst && win_req) begin
         in_flit_ready[win_idx] = slot_free;
      end
   end

   assign win_flit = in_flit[win_idx];
   assign xfer     = in_flit_valid[win_idx] && in_flit_ready[win_idx];

   always_comb begin
      state_d  = state_q;
      flit_d   = flit_q;
      vld_d    = vld_q;
      grant_d  = grant_q;
      rr_ptr_d = rr_ptr_q;
      if (xfer) begin
         flit_d  = win_flit;
         vld_d   = 1'b1;
         grant_d = win_idx;
         if (is_tail_flit(win_flit)) begin
            state_d  = IDLE;
            rr_ptr_d = (win_idx == LAST_PORT) ? '0 : win_idx + PORT_ID_WIDTH'(1);
         end else begin
            state_d = LOCKED;
         end
      end else if (out_flit_ready) begin
         vld_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         flit_q   <= '0;
         vld_q    <= 1'b0;
         grant_q  <= '0;
         rr_ptr_q <= '0;
      end else begin
         state_q  <= state_d;
         flit_q   <= flit_d;
         vld_q    <= vld_d;
         grant_q  <= grant_d;
         rr_ptr_q <= rr_ptr_d;
      end
   end

   assign out_flit       = flit_q;
   assign out_flit_valid = vld_q;
   assign grant_port     = grant_q;
   assign locked         = (state_q == LOCKED);

endmodule

// File: tb/tb_flit_rr_arbiter.sv
// Scenario bench for flit_rr_arbiter (4 ports): expected flits are queued as
// stimulus is driven and compared as they reach out_flit.
module tb_flit_rr_arbiter;
   import flit_rr_arbiter_pkg::*;

   localparam int NP = 4;

   logic           clk = 1'b0;
   logic           rst;
   flit_t [NP-1:0] in_flit;
   logic [NP-1:0]  in_flit_valid;
   logic [NP-1:0]  in_flit_ready;
   flit_t          out_flit;
   logic           out_flit_valid;
   logic           out_flit_ready;
   logic [1:0]     grant_port;
   logic           locked;

   typedef struct {
      logic [7:0] id;
      logic [1:0] port;
   } exp_t;

   exp_t exp_q[$];
   int   n_vec = 0;
   int   n_err = 0;

   flit_rr_arbiter #(.NUM_PORTS(NP)) dut (
      .clk            (clk),
      .rst            (rst),
      .in_flit        (in_flit),
      .in_flit_valid  (in_flit_valid),
      .in_flit_ready  (in_flit_ready),
      .out_flit       (out_flit),
      .out_flit_valid (out_flit_valid),
      .out_flit_ready (out_flit_ready),
      .grant_port     (grant_port),
      .locked         (locked)
   );

   always #5 clk = ~clk;

   function automatic flit_t mk(input flit_type_e t, input logic [7:0] id);
      flit_t f;
      f.ftype   = t;
      f.src_id  = id;
      f.payload = {14'h0, id};
      return f;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst            = 1'b1;
      out_flit_ready = 1'b1;
      in_flit_valid  = 4'b1111;
      for (int i = 0; i < NP; i++) in_flit[i] = mk(FLIT_HEAD_TAIL, 8'(8'h10 + i));
      for (int c = 0; c < 2; c++) begin
         step();
         n_vec++;
         if (in_flit_ready !== 4'b0000 || out_flit_valid !== 1'b0 ||
             grant_port !== 2'd0 || locked !== 1'b0) begin
            n_err++;
            $display("FAIL reset: got rdy=%b v=%b grant=%0d locked=%b, want rdy=0000 v=0 grant=0 locked=0",
                     in_flit_ready, out_flit_valid, grant_port, locked);
         end
      end
      in_flit_valid = '0;
      rst = 1'b0;
   endtask

   task automatic test_fairness();
      exp_t e;
      for (int i = 0; i < NP; i++) in_flit[i] = mk(FLIT_HEAD_TAIL, 8'(8'h10 + i));
      in_flit_valid = 4'b1111;
      for (int k = 0; k < 5; k++) exp_q.push_back('{id: 8'(8'h10 + (k % 4)), port: 2'(k % 4)});
      for (int c = 0; c < 5; c++) begin
         step();
         if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL fair_sb: got empty scoreboard, want an entry");
         end else begin
            e = exp_q.pop_front();
            n_vec++;
            if (out_flit_valid !== 1'b1 || out_flit.src_id !== e.id || grant_port !== e.port) begin
               n_err++;
               $display("FAIL fair_out: got v=%b id=%h grant=%0d, want v=1 id=%h grant=%0d",
                        out_flit_valid, out_flit.src_id, grant_port, e.id, e.port);
            end
         end
      end
      in_flit_valid = '0;
      step();
      n_vec++;
      if (out_flit_valid !== 1'b0) begin
         n_err++;
         $display("FAIL fair_drain: got v=%b, want v=0", out_flit_valid);
      end
   endtask

   task automatic test_lock();
      exp_t e;
      flit_type_e ty[3] = '{FLIT_HEAD, FLIT_BODY, FLIT_TAIL};
      in_flit[2]    = mk(FLIT_HEAD_TAIL, 8'h24);
      in_flit_valid = 4'b0110;
      for (int c = 0; c < 3; c++) begin
         in_flit[1] = mk(ty[c], 8'(8'h21 + c));
         exp_q.push_back('{id: 8'(8'h21 + c), port: 2'd1});
         #1;
         n_vec++;
         if (in_flit_ready !== 4'b0010) begin
            n_err++;
            $display("FAIL lock_rdy: got rdy=%b, want rdy=0010", in_flit_ready);
         end
         step();
         e = exp_q.pop_front();
         n_vec++;
         if (out_flit_valid !== 1'b1 || out_flit.src_id !== e.id || grant_port !== e.port ||
             locked !== (c < 2)) begin
            n_err++;
            $display("FAIL lock_out: got v=%b id=%h grant=%0d locked=%b, want v=1 id=%h grant=%0d locked=%b",
                     out_flit_valid, out_flit.src_id, grant_port, locked, e.id, e.port, c < 2);
         end
      end
      in_flit_valid = 4'b0100;
      exp_q.push_back('{id: 8'h24, port: 2'd2});
      step();
      e = exp_q.pop_front();
      n_vec++;
      if (out_flit_valid !== 1'b1 || out_flit.src_id !== e.id || grant_port !== e.port || locked !== 1'b0) begin
         n_err++;
         $display("FAIL lock_next: got v=%b id=%h grant=%0d locked=%b, want v=1 id=%h grant=%0d locked=0",
                  out_flit_valid, out_flit.src_id, grant_port, locked, e.id, e.port);
      end
      in_flit_valid = '0;
      step();
   endtask

   task automatic test_wrap();
      exp_t e;
      in_flit[3]    = mk(FLIT_HEAD_TAIL, 8'h53);
      in_flit[0]    = mk(FLIT_HEAD_TAIL, 8'h50);
      in_flit[1]    = mk(FLIT_HEAD_TAIL, 8'h51);
      in_flit_valid = 4'b1001;
      exp_q.push_back('{id: 8'h53, port: 2'd3});
      exp_q.push_back('{id: 8'h50, port: 2'd0});
      for (int c = 0; c < 2; c++) begin
         step();
         e = exp_q.pop_front();
         n_vec++;
         if (out_flit_valid !== 1'b1 || out_flit.src_id !== e.id || grant_port !== e.port) begin
            n_err++;
            $display("FAIL wrap_out: got v=%b id=%h grant=%0d, want v=1 id=%h grant=%0d",
                     out_flit_valid, out_flit.src_id, grant_port, e.id, e.port);
         end
      end
      // pointer now at 1: port 1 must beat port 0
      in_flit_valid = 4'b0011;
      #1;
      n_vec++;
      if (in_flit_ready !== 4'b0010) begin
         n_err++;
         $display("FAIL wrap_ptr: got rdy=%b, want rdy=0010", in_flit_ready);
      end
      step();
      in_flit_valid = '0;
      step();
   endtask

   task automatic test_backpressure();
      exp_t e;
      in_flit[2]    = mk(FLIT_HEAD_TAIL, 8'h31);
      in_flit_valid = 4'b0100;
      exp_q.push_back('{id: 8'h31, port: 2'd2});
      step();
      e = exp_q.pop_front();
      n_vec++;
      if (out_flit_valid !== 1'b1 || out_flit.src_id !== e.id) begin
         n_err++;
         $display("FAIL bp_first: got v=%b id=%h, want v=1 id=%h", out_flit_valid, out_flit.src_id, e.id);
      end
      in_flit[2]     = mk(FLIT_HEAD_TAIL, 8'h32);
      out_flit_ready = 1'b0;
      for (int c = 0; c < 3; c++) begin
         #1;
         n_vec++;
         if (in_flit_ready !== 4'b0000) begin
            n_err++;
            $display("FAIL bp_rdy: got rdy=%b, want rdy=0000", in_flit_ready);
         end
         step();
         n_vec++;
         if (out_flit_valid !== 1'b1 || out_flit.src_id !== 8'h31) begin
            n_err++;
            $display("FAIL bp_hold: got v=%b id=%h, want v=1 id=31", out_flit_valid, out_flit.src_id);
         end
      end
      out_flit_ready = 1'b1;
      exp_q.push_back('{id: 8'h32, port: 2'd2});
      step();
      e = exp_q.pop_front();
      n_vec++;
      if (out_flit_valid !== 1'b1 || out_flit.src_id !== e.id || grant_port !== e.port) begin
         n_err++;
         $display("FAIL bp_release: got v=%b id=%h grant=%0d, want v=1 id=%h grant=%0d",
                  out_flit_valid, out_flit.src_id, grant_port, e.id, e.port);
      end
      in_flit_valid = '0;
      step();
      n_vec++;
      if (out_flit_valid !== 1'b0) begin
         n_err++;
         $display("FAIL bp_drain: got v=%b, want v=0", out_flit_valid);
      end
   endtask

   task automatic test_reset_mid_packet();
      exp_t e;
      in_flit[0]    = mk(FLIT_HEAD, 8'h60);
      in_flit_valid = 4'b0001;
      exp_q.push_back('{id: 8'h60, port: 2'd0});
      step();
      e = exp_q.pop_front();
      n_vec++;
      if (out_flit_valid !== 1'b1 || out_flit.src_id !== e.id || locked !== 1'b1) begin
         n_err++;
         $display("FAIL rmid_head: got v=%b id=%h locked=%b, want v=1 id=%h locked=1",
                  out_flit_valid, out_flit.src_id, locked, e.id);
      end
      rst           = 1'b1;
      in_flit[0]    = mk(FLIT_BODY, 8'h61);
      in_flit[2]    = mk(FLIT_HEAD_TAIL, 8'h62);
      in_flit_valid = 4'b0101;
      step();
      n_vec++;
      if (locked !== 1'b0 || out_flit_valid !== 1'b0 || in_flit_ready !== 4'b0000) begin
         n_err++;
         $display("FAIL rmid_rst: got locked=%b v=%b rdy=%b, want locked=0 v=0 rdy=0000",
                  locked, out_flit_valid, in_flit_ready);
      end
      // upstream port 0 is reset too; a stale lock would refuse port 2 here
      rst           = 1'b0;
      in_flit_valid = 4'b0100;
      exp_q.push_back('{id: 8'h62, port: 2'd2});
      #1;
      n_vec++;
      if (in_flit_ready !== 4'b0100) begin
         n_err++;
         $display("FAIL rmid_rdy: got rdy=%b, want rdy=0100", in_flit_ready);
      end
      step();
      e = exp_q.pop_front();
      n_vec++;
      if (out_flit_valid !== 1'b1 || out_flit.src_id !== e.id || grant_port !== e.port || locked !== 1'b0) begin
         n_err++;
         $display("FAIL rmid_grant: got v=%b id=%h grant=%0d locked=%b, want v=1 id=%h grant=%0d locked=0",
                  out_flit_valid, out_flit.src_id, grant_port, locked, e.id, e.port);
      end
      in_flit_valid = '0;
      step();
   endtask

   initial begin
      test_reset();
      test_fairness();
      test_lock();
      test_wrap();
      test_backpressure();
      test_reset_mid_packet();
      if (exp_q.size() != 0) begin
         n_err++;
         $display("FAIL sb_leftover: got %0d entries, want 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, want completion");
      $fatal(1, "watchdog expired");
   end

endmodule
